demux_1to4_reg: RTL and testbench
=================================

Name: demux_1to4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the distribution-side counterpart of the team's 4-to-1 data selector.
- Takes one `ancho`-bit input stream with a valid/ready handshake and steers each accepted word into one of four output holding registers.
- Each output channel has its own valid flag and acknowledge.
- Sits between a single producer and four independent consumers.

Parameters:
- ancho, 4, data width of D and of each output channel Y0..Y3
- CNT_W, 8, width of the accepted-transfer counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- D  input  ancho  input data word
- sel  input  2  destination channel: 2'b00 selects Y0, 2'b01 Y1, 2'b10 Y2, 2'b11 Y3
- in_valid  input  1  D/sel valid this cycle
- in_ready  output  1  block can accept D this cycle
- Y0, Y1, Y2, Y3  output  ancho each  channel holding registers
- vld  output  4  vld[k]=1 means Yk holds an unconsumed word
- ack  input  4  ack[k]=1 means the consumer takes Yk this cycle; meaningful only while vld[k]=1
- xfer_cnt  output  CNT_W  count of accepted input transfers

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Y0..Y3 = 0, vld = 4'b0000, xfer_cnt = 0.
  - Round-robin pointer (if compiled in) = 0.
  - in_ready depends only on the current state, so in_ready = 1 after reset.
- Target channel t: equals sel, or the rr pointer when DEMUX_RR_EN is defined.
- Acceptance rule:
  - in_ready = ~vld[t] | ack[t]. This is combinational from registered state and ack. It has no path from D.
  - A transfer occurs when in_valid & in_ready at a rising edge.
- On a transfer, at the next edge:
  - Y[t] <= D and vld[t] <= 1. Latency from input to output is 1 cycle.
  - xfer_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
- Consume: ack[k] & vld[k] at an edge with no simultaneous write to k gives vld[k] <= 0. Y[k] keeps its last value.
- Write-through (transfer to t and ack[t] in the same cycle): vld[t] stays 1 and Y[t] takes the new D. No bubble occurs and no word is lost.
- Ignored ack: ack[k] while vld[k]=0 has no effect.
- Full channel:
  - If vld[t]=1 and ack[t]=0, then in_ready=0 and D is not captured.
  - The producer must hold D/sel stable while in_valid is high until the transfer.
  - Channels other than t are unaffected and may be acked freely.
- Independence: acks on multiple channels in the same cycle are all honoured. At most one channel is written per cycle.
- in_valid=0: no state change except acks.
- Reset mid-operation: all pending words are discarded (vld cleared). Nothing is replayed after reset.

Optional Feature:
- Macro: DEMUX_RR_EN.
- Defined:
  - sel is ignored.
  - A 2-bit rr pointer selects t and advances 0→1→2→3→0 only on an accepted transfer.
  - The pointer holds while in_ready=0 (strict order; it never skips a full channel).
- Not defined: t = sel and no pointer register exists.
- The port list is identical in both builds.

Test Plan:
- Reset, then D=4'hA, sel=2'b10, in_valid=1 for 1 cycle → next cycle Y2=4'hA, vld=4'b0100, xfer_cnt=1, and Y0/Y1/Y3 stay 0.
- With vld[1]=1 and ack=0, present D=4'h5, sel=2'b01, in_valid=1 → in_ready=0 and Y1 unchanged. Then raise ack[1] → transfer the same cycle, Y1=4'h5, vld[1] stays 1, xfer_cnt +1.
- Fill all four channels (D=1,2,3,4 to sel=0..3), then ack=4'b1111 for one cycle → vld=4'b0000, Y0..Y3 keep 1,2,3,4.
- Perform 256 transfers with ack held at 4'b1111 → xfer_cnt reads 0 after the 256th and 1 after the 257th.
- Assert rst_n=0 asynchronously mid-cycle with vld=4'b1011 → immediately vld=0, Y*=0, xfer_cnt=0, in_ready=1.
- DEMUX_RR_EN build: send D=7,8,9,A,B with sel=3 throughout and ack=4'b1111 → words land in Y0,Y1,Y2,Y3,Y0 in that order. Then hold ack[1]=0 with vld[1]=1 and pointer=1 → in_ready=0 and the pointer stays at 1.

Source files
------------

// File: rtl/demux_1to4_reg_if.sv
// Handshake bus for the registered 1-to-4 demux: one producer stream in, four
// consumer channels out, each with its own valid/ack pair.
interface demux_1to4_reg_if #(
  parameter int unsigned ancho = 4
);
  logic [ancho-1:0] D;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [ancho-1:0] Y0;
  logic [ancho-1:0] Y1;
  logic [ancho-1:0] Y2;
  logic [ancho-1:0] Y3;
  logic [3:0]       vld;
  logic [3:0]       ack;

  modport master (
    output D, sel, in_valid, ack,
    input  in_ready, Y0, Y1, Y2, Y3, vld
  );

  modport slave (
    input  D, sel, in_valid, ack,
    output in_ready, Y0, Y1, Y2, Y3, vld
  );
endinterface

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel holding registers and valid/ack.
// Define DEMUX_RR_EN to replace sel with a strict round-robin target pointer.
module demux_1to4_reg #(
  parameter int unsigned ancho = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1to4_reg_if.slave  bus,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [ancho-1:0] y_q [4];
  logic [ancho-1:0] y_d [4];
  logic [3:0]       vld_q, vld_d;
  logic [3:0]       wr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt;
  logic             ready;
  logic             xfer;

`ifdef DEMUX_RR_EN
  logic [1:0] rr_q;
  logic       unused_sel;

  assign unused_sel = ^bus.sel;
  assign tgt        = rr_q;

  // Pointer only moves on an accepted word, so a full channel stalls the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 2'd0;
    end else if (xfer) begin
      rr_q <= rr_q + 2'd1;
    end
  end
`else
  assign tgt = bus.sel;
`endif

  // An ack on the target frees the slot in the same cycle (write-through).
  assign ready = ~vld_q[tgt] | bus.ack[tgt];
  assign xfer  = bus.in_valid & ready;

  always_comb begin
    wr = 4'b0000;
    if (xfer) begin
      wr[tgt] = 1'b1;
    end
    vld_d = (vld_q & ~bus.ack) | wr;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
    for (int k = 0; k < 4; k++) begin
      y_d[k] = wr[k] ? bus.D : y_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= '0;
      end
      vld_q <= 4'b0000;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= y_d[k];
      end
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.vld      = vld_q;
  assign bus.Y0       = y_q[0];
  assign bus.Y1       = y_q[1];
  assign bus.Y2       = y_q[2];
  assign bus.Y3       = y_q[3];
  assign xfer_cnt     = cnt_q;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Self-checking bench for demux_1to4_reg: a scoreboard queue holds the word and
// channel each accepted transfer must land in; tasks pop and compare after the edge.
module tb_demux_1to4_reg;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] xfer_cnt;

  demux_1to4_reg_if #(.ancho(4)) bus ();

  demux_1to4_reg #(.ancho(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  int   n_vec;
  int   n_err;
  sb_t  sb_q[$];
  logic [3:0] exp_vld;
  logic [7:0] exp_cnt;
  logic [1:0] exp_rr;
  logic       exp_ready;
  logic       ready_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] get_y(input int k);
    case (k)
      0:       return bus.Y0;
      1:       return bus.Y1;
      2:       return bus.Y2;
      default: return bus.Y3;
    endcase
  endfunction

  task automatic model_reset();
    exp_vld = 4'b0000;
    exp_cnt = 8'd0;
    exp_rr  = 2'd0;
    sb_q.delete();
  endtask

  // Drives one cycle, updates the reference model, and returns 1 after the edge.
  task automatic cycle(input logic [3:0] d, input logic [1:0] s, input logic v,
                       input logic [3:0] a);
    logic [1:0] t;
    logic [3:0] w;
    bus.D        = d;
    bus.sel      = s;
    bus.in_valid = v;
    bus.ack      = a;
    #1;
    ready_seen = bus.in_ready;
`ifdef DEMUX_RR_EN
    t = exp_rr;
`else
    t = s;
`endif
    exp_ready = ~exp_vld[t] | a[t];
    w = 4'b0000;
    if (v && exp_ready) begin
      w[t] = 1'b1;
      sb_q.push_back('{ch: t, data: d});
      exp_cnt = exp_cnt + 8'd1;
      exp_rr  = exp_rr + 2'd1;
    end
    exp_vld = (exp_vld & ~a) | w;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ack      = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.D        = '0;
    bus.sel      = '0;
    bus.in_valid = 1'b0;
    bus.ack      = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.vld !== 4'b0000) begin
      n_err++; $display("FAIL reset_vld: got %b expected 0000", bus.vld);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (get_y(k) !== 4'h0) begin
        n_err++; $display("FAIL reset_y%0d: got %h expected 0", k, get_y(k));
      end
    end
    n_vec++;
    if (xfer_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    sb_t e;
    cycle(4'hA, 2'b10, 1'b1, 4'b0000);
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL basic_accept: got no transfer expected one");
    end else begin
      e = sb_q.pop_front();
      if (get_y(e.ch) !== e.data) begin
        n_err++; $display("FAIL basic_y: got %h expected %h", get_y(e.ch), e.data);
      end
    end
    n_vec++;
    if (bus.Y2 !== 4'hA) begin
      n_err++; $display("FAIL basic_y2: got %h expected a", bus.Y2);
    end
    n_vec++;
    if (bus.vld !== 4'b0100) begin
      n_err++; $display("FAIL basic_vld: got %b expected 0100", bus.vld);
    end
    n_vec++;
    if (xfer_cnt !== 8'd1) begin
      n_err++; $display("FAIL basic_cnt: got %0d expected 1", xfer_cnt);
    end
    n_vec++;
    if ({bus.Y0, bus.Y1, bus.Y3} !== 12'h000) begin
      n_err++; $display("FAIL basic_others: got %h expected 000", {bus.Y0, bus.Y1, bus.Y3});
    end
  endtask

  task automatic test_full_channel();
    sb_t e;
    cycle(4'h3, 2'b01, 1'b1, 4'b0000);
    e = sb_q.pop_front();
    n_vec++;
    if (get_y(e.ch) !== e.data) begin
      n_err++; $display("FAIL full_prefill: got %h expected %h", get_y(e.ch), e.data);
    end
    // Channel 1 full and not acked; a different channel is acked meanwhile.
    cycle(4'h5, 2'b01, 1'b1, 4'b0100);
    n_vec++;
    if (ready_seen !== 1'b0) begin
      n_err++; $display("FAIL full_ready: got %b expected 0", ready_seen);
    end
    n_vec++;
    if (bus.Y1 !== 4'h3) begin
      n_err++; $display("FAIL full_hold: got %h expected 3", bus.Y1);
    end
    n_vec++;
    if (bus.vld !== exp_vld || xfer_cnt !== exp_cnt) begin
      n_err++; $display("FAIL full_state: got %b/%0d expected %b/%0d",
                        bus.vld, xfer_cnt, exp_vld, exp_cnt);
    end
    cycle(4'h5, 2'b01, 1'b1, 4'b0010);
    n_vec++;
    if (ready_seen !== 1'b1) begin
      n_err++; $display("FAIL wt_ready: got %b expected 1", ready_seen);
    end
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL wt_accept: got no transfer expected one");
    end else begin
      e = sb_q.pop_front();
      if (get_y(e.ch) !== e.data) begin
        n_err++; $display("FAIL wt_y: got %h expected %h", get_y(e.ch), e.data);
      end
    end
    n_vec++;
    if (bus.vld[1] !== 1'b1 || xfer_cnt !== exp_cnt) begin
      n_err++; $display("FAIL wt_state: got %b/%0d expected 1/%0d",
                        bus.vld[1], xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_fill_ack();
    sb_t e;
    cycle(4'h0, 2'b00, 1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      cycle(4'(i + 1), 2'(i), 1'b1, 4'b0000);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL fill_accept%0d: got none expected one", i);
      end else begin
        e = sb_q.pop_front();
        if (get_y(e.ch) !== e.data) begin
          n_err++; $display("FAIL fill_y%0d: got %h expected %h", i, get_y(e.ch), e.data);
        end
      end
    end
    n_vec++;
    if (bus.vld !== 4'b1111) begin
      n_err++; $display("FAIL fill_vld: got %b expected 1111", bus.vld);
    end
    cycle(4'h0, 2'b00, 1'b0, 4'b1111);
    n_vec++;
    if (bus.vld !== 4'b0000) begin
      n_err++; $display("FAIL ackall_vld: got %b expected 0000", bus.vld);
    end
    n_vec++;
    if ({bus.Y3, bus.Y2, bus.Y1, bus.Y0} !== 16'h4321) begin
      n_err++; $display("FAIL ackall_keep: got %h expected 4321",
                        {bus.Y3, bus.Y2, bus.Y1, bus.Y0});
    end
    // Acks on empty channels must change nothing.
    cycle(4'h0, 2'b00, 1'b0, 4'b1111);
    n_vec++;
    if (bus.vld !== 4'b0000 || {bus.Y3, bus.Y2, bus.Y1, bus.Y0} !== 16'h4321) begin
      n_err++; $display("FAIL idle_ack: got %b/%h expected 0000/4321",
                        bus.vld, {bus.Y3, bus.Y2, bus.Y1, bus.Y0});
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 257; i++) begin
      cycle(4'($urandom), 2'($urandom), 1'b1, 4'b1111);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL b2b_accept%0d: got none expected one", i);
      end else begin
        e = sb_q.pop_front();
        if (get_y(e.ch) !== e.data || bus.vld !== exp_vld) begin
          n_err++; $display("FAIL b2b_%0d: got %h/%b expected %h/%b",
                            i, get_y(e.ch), bus.vld, e.data, exp_vld);
        end
      end
      if (i == 256) begin
        n_vec++;
        if (xfer_cnt !== 8'd0) begin
          n_err++; $display("FAIL wrap_256: got %0d expected 0", xfer_cnt);
        end
      end
      if (i == 257) begin
        n_vec++;
        if (xfer_cnt !== 8'd1) begin
          n_err++; $display("FAIL wrap_257: got %0d expected 1", xfer_cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    sb_t e;
    logic [1:0] chs [3];
    chs[0] = 2'd0;
    chs[1] = 2'd1;
    chs[2] = 2'd3;
    cycle(4'h0, 2'b00, 1'b0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cycle(4'(i + 9), chs[i], 1'b1, 4'b0000);
      e = sb_q.pop_front();
      n_vec++;
      if (get_y(e.ch) !== e.data) begin
        n_err++; $display("FAIL ar_fill%0d: got %h expected %h", i, get_y(e.ch), e.data);
      end
    end
    n_vec++;
    if (bus.vld !== 4'b1011) begin
      n_err++; $display("FAIL ar_pre_vld: got %b expected 1011", bus.vld);
    end
    bus.D        = 4'h6;
    bus.sel      = 2'b10;
    bus.in_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.vld !== 4'b0000 || xfer_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL ar_now: got %b/%0d/%b expected 0000/0/1",
                        bus.vld, xfer_cnt, bus.in_ready);
    end
    n_vec++;
    if ({bus.Y3, bus.Y2, bus.Y1, bus.Y0} !== 16'h0000) begin
      n_err++; $display("FAIL ar_y: got %h expected 0000", {bus.Y3, bus.Y2, bus.Y1, bus.Y0});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    model_reset();
    cycle(4'h0, 2'b00, 1'b0, 4'b0000);
    n_vec++;
    if (bus.vld !== 4'b0000 || xfer_cnt !== 8'd0) begin
      n_err++; $display("FAIL ar_no_replay: got %b/%0d expected 0000/0", bus.vld, xfer_cnt);
    end
  endtask

  task automatic test_round_robin();
    sb_t e;
    logic [3:0] words [5];
    int         order [5];
    words[0] = 4'h7; words[1] = 4'h8; words[2] = 4'h9; words[3] = 4'hA; words[4] = 4'hB;
    order[0] = 0;    order[1] = 1;    order[2] = 2;    order[3] = 3;    order[4] = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(words[i], 2'b11, 1'b1, 4'b1111);
      if (sb_q.size() != 0) e = sb_q.pop_front();
      n_vec++;
      if (get_y(order[i]) !== words[i]) begin
        n_err++; $display("FAIL rr_order%0d: got %h expected %h", i, get_y(order[i]), words[i]);
      end
    end
    cycle(4'h0, 2'b11, 1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      cycle(4'(i + 1), 2'b11, 1'b1, 4'b0000);
      if (sb_q.size() != 0) e = sb_q.pop_front();
    end
    n_vec++;
    if (bus.vld !== 4'b1111 || bus.Y1 !== 4'h1 || bus.Y0 !== 4'h4) begin
      n_err++; $display("FAIL rr_fill: got %b/%h/%h expected 1111/1/4",
                        bus.vld, bus.Y1, bus.Y0);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(4'hC, 2'b11, 1'b1, 4'b0000);
      n_vec++;
      if (ready_seen !== 1'b0) begin
        n_err++; $display("FAIL rr_stall%0d: got %b expected 0", i, ready_seen);
      end
    end
    cycle(4'hC, 2'b11, 1'b1, 4'b0010);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    n_vec++;
    if (bus.Y1 !== 4'hC || bus.Y0 !== 4'h4 || xfer_cnt !== exp_cnt) begin
      n_err++; $display("FAIL rr_hold_ptr: got %h/%h/%0d expected c/4/%0d",
                        bus.Y1, bus.Y0, xfer_cnt, exp_cnt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    test_reset();
`ifdef DEMUX_RR_EN
    test_round_robin();
`else
    test_basic();
    test_full_channel();
    test_fill_ack();
    test_back_to_back();
    test_async_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
